// File: rtl/cmp_arb_pkg.sv
// rtl/cmp_arb_pkg.sv - shared types, constants and round-robin search for cmp_arbiter
package cmp_arb_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CMP  = 2'd1,
      RESP = 2'd2
   } state_e;

   localparam int CMP_W   = 4;
   localparam int MAX_REQ = 8;

   typedef struct packed {
      logic       found;
      logic [2:0] idx;
   } rr_pick_t;

   // First set bit at or above ptr, wrapping at nreq; sized for the largest legal NREQ.
   function automatic rr_pick_t rr_pick(input logic [MAX_REQ-1:0] valid,
                                        input logic [2:0]         ptr,
                                        input int unsigned        nreq);
      rr_pick_t   r;
      logic [2:0] idx;
      r = '0;
      for (int unsigned k = 0; k < MAX_REQ; k++) begin
         idx = 3'((32'(ptr) + k) % nreq);
         if (k < nreq && !r.found && valid[idx]) begin
            r.found = 1'b1;
            r.idx   = idx;
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/comparator.sv
// rtl/comparator.sv - unsigned magnitude comparator
module comparator #(
   parameter int W = 4
) (
   input  logic [W-1:0] a_i,
   input  logic [W-1:0] b_i,
   output logic         less_o,
   output logic         equal_o,
   output logic         greater_o
);

   assign less_o    = (a_i <  b_i);
   assign equal_o   = (a_i == b_i);
   assign greater_o = (a_i >  b_i);

endmodule

// File: rtl/cmp_arbiter.sv
// rtl/cmp_arbiter.sv - round-robin arbiter sharing one comparator between NREQ requesters
module cmp_arbiter
   import cmp_arb_pkg::*;
#(
   parameter  int NREQ = 4,
   localparam int IDW  = $clog2(NREQ)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NREQ-1:0]       req_valid,
   output logic [NREQ-1:0]       req_ready,
   input  logic [CMP_W*NREQ-1:0] req_a,
   input  logic [CMP_W*NREQ-1:0] req_b,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [IDW-1:0]        rsp_id,
   output logic                  rsp_less,
   output logic                  rsp_equal,
   output logic                  rsp_greater,
   output logic                  busy
);

   state_e            state_q, state_d;
   logic [IDW-1:0]    rr_ptr_q, rr_ptr_d;
   logic [IDW-1:0]    op_id_q, op_id_d;
   logic [CMP_W-1:0]  op_a_q, op_a_d;
   logic [CMP_W-1:0]  op_b_q, op_b_d;
   logic              rsp_valid_q, rsp_valid_d;
   logic [IDW-1:0]    rsp_id_q, rsp_id_d;
   logic              rsp_less_q, rsp_less_d;
   logic              rsp_equal_q, rsp_equal_d;
   logic              rsp_greater_q, rsp_greater_d;

   logic              cmp_less, cmp_equal, cmp_greater;
   rr_pick_t          pick;
   logic [IDW-1:0]    winner;
   logic [IDW-1:0]    ptr_after;

   comparator #(.W(CMP_W)) u_cmp (
      .a_i       (op_a_q),
      .b_i       (op_b_q),
      .less_o    (cmp_less),
      .equal_o   (cmp_equal),
      .greater_o (cmp_greater)
   );

   assign pick      = rr_pick(MAX_REQ'(req_valid), 3'(rr_ptr_q), NREQ);
   assign winner    = IDW'(pick.idx);
   assign ptr_after = (op_id_q == IDW'(NREQ - 1)) ? '0 : op_id_q + 1'b1;

   always_comb begin
      state_d       = state_q;
      rr_ptr_d      = rr_ptr_q;
      op_id_d       = op_id_q;
      op_a_d        = op_a_q;
      op_b_d        = op_b_q;
      rsp_valid_d   = rsp_valid_q;
      rsp_id_d      = rsp_id_q;
      rsp_less_d    = rsp_less_q;
      rsp_equal_d   = rsp_equal_q;
      rsp_greater_d = rsp_greater_q;
      req_ready     = '0;
      case (state_q)
         IDLE: begin
            // Gated by rst so no requester believes it was accepted while reset drops the grant.
            if (pick.found && !rst) begin
               req_ready = NREQ'(1) << winner;
               op_id_d   = winner;
               op_a_d    = req_a[CMP_W*int'(winner) +: CMP_W];
               op_b_d    = req_b[CMP_W*int'(winner) +: CMP_W];
               state_d   = CMP;
            end
         end
         CMP: begin
            rsp_less_d    = cmp_less;
            rsp_equal_d   = cmp_equal;
            rsp_greater_d = cmp_greater;
            rsp_id_d      = op_id_q;
            rsp_valid_d   = 1'b1;
            state_d       = RESP;
         end
         RESP: begin
            if (rsp_ready) begin
               rsp_valid_d = 1'b0;
               rr_ptr_d    = ptr_after;
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= IDLE;
         rr_ptr_q      <= '0;
         op_id_q       <= '0;
         op_a_q        <= '0;
         op_b_q        <= '0;
         rsp_valid_q   <= 1'b0;
         rsp_id_q      <= '0;
         rsp_less_q    <= 1'b0;
         rsp_equal_q   <= 1'b0;
         rsp_greater_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         rr_ptr_q      <= rr_ptr_d;
         op_id_q       <= op_id_d;
         op_a_q        <= op_a_d;
         op_b_q        <= op_b_d;
         rsp_valid_q   <= rsp_valid_d;
         rsp_id_q      <= rsp_id_d;
         rsp_less_q    <= rsp_less_d;
         rsp_equal_q   <= rsp_equal_d;
         rsp_greater_q <= rsp_greater_d;
      end
   end

   assign rsp_valid   = rsp_valid_q;
   assign rsp_id      = rsp_id_q;
   assign rsp_less    = rsp_less_q;
   assign rsp_equal   = rsp_equal_q;
   assign rsp_greater = rsp_greater_q;
   assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_cmp_arbiter.sv
// tb/tb_cmp_arbiter.sv - directed scoreboard bench for cmp_arbiter
module tb_cmp_arbiter;
   import cmp_arb_pkg::*;

   localparam int NREQ = 4;
   localparam int IDW  = 2;

   logic                  clk;
   logic                  rst;
   logic [NREQ-1:0]       req_valid;
   logic [NREQ-1:0]       req_ready;
   logic [4*NREQ-1:0]     req_a;
   logic [4*NREQ-1:0]     req_b;
   logic                  rsp_valid;
   logic                  rsp_ready;
   logic [IDW-1:0]        rsp_id;
   logic                  rsp_less;
   logic                  rsp_equal;
   logic                  rsp_greater;
   logic                  busy;

   cmp_arbiter #(.NREQ(NREQ)) dut (
      .clk         (clk),
      .rst         (rst),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_a       (req_a),
      .req_b       (req_b),
      .rsp_valid   (rsp_valid),
      .rsp_ready   (rsp_ready),
      .rsp_id      (rsp_id),
      .rsp_less    (rsp_less),
      .rsp_equal   (rsp_equal),
      .rsp_greater (rsp_greater),
      .busy        (busy)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int             n_cmp = 0;
   int             n_err = 0;
   int             cyc   = 0;
   state_e         m_state = IDLE;
   int             m_ptr   = 0;
   logic [IDW+2:0] sb[$];
   int             g_id[$];
   int             g_cyc[$];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic set_op(input int i, input logic [3:0] a, input logic [3:0] b);
      req_a[4*i +: 4] = a;
      req_b[4*i +: 4] = b;
   endtask

   // One clock: check outputs at the falling edge against the model, then advance the model.
   task automatic cycle(output logic [NREQ-1:0] g);
      logic [NREQ-1:0] exp_ready;
      logic [IDW+2:0]  e;
      logic [3:0]      a, b;
      int              j, win;
      bit              found;
      @(negedge clk);
      exp_ready = '0;
      found     = 1'b0;
      win       = 0;
      if (!rst && m_state == IDLE) begin
         for (int k = 0; k < NREQ; k++) begin
            j = (m_ptr + k) % NREQ;
            if (!found && req_valid[j]) begin
               found = 1'b1;
               win   = j;
            end
         end
         if (found) exp_ready[win] = 1'b1;
      end
      check("req_ready", 32'(req_ready), 32'(exp_ready));
      check("busy", 32'(busy), 32'(m_state != IDLE));
      check("rsp_valid", 32'(rsp_valid), 32'(m_state == RESP));
      if (m_state == RESP) begin
         check("sb_nonempty", 32'(sb.size() > 0), 32'd1);
         if (sb.size() > 0) begin
            check("rsp_id", 32'(rsp_id), 32'(sb[0][IDW+2:3]));
            check("rsp_flags", 32'({rsp_less, rsp_equal, rsp_greater}), 32'(sb[0][2:0]));
         end
      end
      g = req_ready;
      if (rst) begin
         m_state = IDLE;
         m_ptr   = 0;
         sb.delete();
      end else begin
         case (m_state)
            IDLE: if (found) begin
               a = req_a[4*win +: 4];
               b = req_b[4*win +: 4];
               e = {IDW'(win), a < b, a == b, a > b};
               sb.push_back(e);
               g_id.push_back(win);
               g_cyc.push_back(cyc);
               m_state = CMP;
            end
            CMP:  m_state = RESP;
            RESP: if (rsp_ready) begin
               e       = sb.pop_front();
               m_ptr   = (int'(e[IDW+2:3]) + 1) % NREQ;
               m_state = IDLE;
            end
            default: m_state = IDLE;
         endcase
      end
      cyc++;
      @(posedge clk);
      #1;
   endtask

   // Requesters drop their valid once they see their ready.
   task automatic run(input int n);
      logic [NREQ-1:0] g;
      for (int i = 0; i < n; i++) begin
         cycle(g);
         req_valid = req_valid & ~g;
      end
   endtask

   initial begin
      logic [NREQ-1:0] g;
      int              base;
      int              r0_grants;

      rst       = 1'b1;
      req_valid = '1;
      req_a     = '0;
      req_b     = '0;
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      @(negedge clk);
      check("reset_req_ready", 32'(req_ready), 32'd0);
      @(posedge clk); #1;
      rst       = 1'b0;
      req_valid = '0;
      @(negedge clk);
      check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
      check("reset_rsp_id", 32'(rsp_id), 32'd0);
      check("reset_flags", 32'({rsp_less, rsp_equal, rsp_greater}), 32'd0);
      check("reset_busy", 32'(busy), 32'd0);
      @(posedge clk); #1;

      // single request, less
      set_op(0, 4'd10, 4'd12);
      req_valid = 4'b0001;
      run(3);
      check("t1_single_grant", 32'(g_id.size()), 32'd1);
      run(2);

      // all valid continuously from rr_ptr=0
      rst = 1'b1; cycle(g); rst = 1'b0;
      set_op(0, 4'd15, 4'd11);
      set_op(1, 4'd10, 4'd10);
      set_op(2, 4'd3,  4'd9);
      set_op(3, 4'd0,  4'd0);
      base      = g_id.size();
      req_valid = 4'b1111;
      for (int i = 0; i < 13; i++) cycle(g);
      req_valid = '0;
      check("t2_grant_count", 32'(g_id.size() - base), 32'd5);
      for (int i = 0; i < 5; i++) begin
         if (base + i < g_id.size()) begin
            check("t2_grant_order", 32'(g_id[base+i]), 32'(i % NREQ));
            if (i > 0) check("t2_grant_spacing", 32'(g_cyc[base+i] - g_cyc[base+i-1]), 32'd3);
         end
      end
      run(3);

      // backpressure for 5 cycles, others stay pending
      set_op(1, 4'd5, 4'd9);
      rsp_ready = 1'b0;
      req_valid = 4'b0010;
      cycle(g);
      check("t3_grant_r1", 32'(g), 32'b0010);
      req_valid = 4'b1101;
      run(6);
      rsp_ready = 1'b1;
      run(2);
      check("t3_next_grant_r2", 32'(g_id[g_id.size()-1]), 32'd2);
      req_valid = '0;
      run(3);

      // wrap-around from rr_ptr=3
      check("t4_ptr", 32'(dut.rr_ptr_q), 32'd3);
      set_op(3, 4'd4, 4'd4);
      set_op(0, 4'd1, 4'd2);
      req_valid = 4'b1001;
      run(8);
      check("t4_wrap_r3", 32'(g_id[g_id.size()-2]), 32'd3);
      check("t4_wrap_r0", 32'(g_id[g_id.size()-1]), 32'd0);

      // reset while in CMP drops the transaction
      set_op(0, 4'd7, 4'd2);
      req_valid = 4'b0001;
      run(1);
      rst = 1'b1;
      cycle(g);
      rst = 1'b0;
      check("t5_ptr_cleared", 32'(dut.rr_ptr_q), 32'd0);
      run(3);
      set_op(1, 4'd6, 4'd6);
      req_valid = 4'b0010;
      run(6);
      check("t5_fresh_grant_r1", 32'(g_id[g_id.size()-1]), 32'd1);

      // boundary operands
      set_op(0, 4'd15, 4'd0);
      set_op(1, 4'd0,  4'd15);
      set_op(2, 4'd15, 4'd15);
      req_valid = 4'b0111;
      run(12);

      // r0 withdraws before its turn
      set_op(3, 4'd8, 4'd3);
      req_valid = 4'b1001;
      run(1);
      check("t6_grant_r3", 32'(g_id[g_id.size()-1]), 32'd3);
      req_valid = '0;
      base = g_id.size();
      run(8);
      r0_grants = 0;
      for (int i = base; i < g_id.size(); i++) if (g_id[i] == 0) r0_grants++;
      check("t6_withdrawn_not_granted", 32'(r0_grants), 32'd0);
      check("final_sb_empty", 32'(sb.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/cmp_arbiter.md
Name: cmp_arbiter

Overview:
- Shares one 4-bit magnitude comparator (`comparator`: A/B in, less/equal/greater out) between NREQ requesters.
- Round-robin arbitration with a valid/ready request handshake and a tagged, back-pressured response.
- Sits between the ALU/memory-side clients and the single comparator instance, so only one comparator is built.

Parameters:
- NREQ, 4, number of requesters (2..8); the ID width is IDW = clog2(NREQ).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- req_valid  input  NREQ  per-requester request valid.
- req_ready  output  NREQ  per-requester accept; one-hot or zero.
- req_a  input  4*NREQ  operand A; requester i uses bits [4i+3:4i].
- req_b  input  4*NREQ  operand B, same packing.
- rsp_valid  output  1  response valid.
- rsp_ready  input  1  response consumer ready.
- rsp_id  output  IDW  index of the requester this response belongs to.
- rsp_less  output  1  A < B (unsigned).
- rsp_equal  output  1  A == B.
- rsp_greater  output  1  A > B.
- busy  output  1  high whenever the state is not IDLE.

Behaviour:
Reset and clocking:
- One clock, clk. Reset rst is synchronous and active-high.
- Reset values: state=IDLE, rr_ptr=0, rsp_valid=0, rsp_id=0, rsp_less=0, rsp_equal=0, rsp_greater=0, busy=0. req_ready is combinational and 0 in reset.

States:
- IDLE:
  - If any req_valid is set, select the winner: the first set bit searching upward from rr_ptr, wrapping NREQ-1 -> 0.
  - Assert req_ready[winner]=1 combinationally in that cycle; this is the handshake. Latch A, B and winner into op_a, op_b, op_id. Go to CMP.
  - If no req_valid is set, stay in IDLE with req_ready=0.
- CMP: the comparator evaluates op_a/op_b. Register its three outputs into rsp_less, rsp_equal and rsp_greater, and op_id into rsp_id. Set rsp_valid=1 and go to RESP.
- RESP: hold rsp_valid and all rsp_* stable until rsp_ready=1. On that edge, clear rsp_valid, set rr_ptr=(op_id+1) mod NREQ and go to IDLE.

Timing:
- Latency: grant in cycle N, rsp_valid first high in cycle N+2.
- Minimum spacing between grants is 3 cycles, because grants are accepted only in IDLE and there is no bypass.

Flags and handshake rules:
- Exactly one of less/equal/greater is 1 whenever rsp_valid=1. All three are 0 after reset until the first response.
- req_ready is never asserted outside IDLE and never to a requester whose req_valid is 0.
- A requester must hold req_valid and its operands until it sees req_ready. A request withdrawn before grant is simply not served; no error is raised.

Boundary cases:
- If rsp_ready is already high when rsp_valid rises, the transaction completes on that edge (one RESP cycle).
- If all NREQ requesters are valid continuously, grants go 0,1,2,..,NREQ-1,0. No requester waits more than NREQ-1 grants.
- rr_ptr wraps from NREQ-1 to 0. rr_ptr advances only when a response completes, not when a grant is issued.
- Reset asserted in any state returns to IDLE on the next edge. The in-flight transaction is dropped with no response, and rr_ptr returns to 0.
- Operands are unsigned 4-bit: 15 > 0 and 0 < 15. There is no sign extension.

Decomposition:
- Package cmp_arb_pkg:
  - state encoding IDLE=2'd0, CMP=2'd1, RESP=2'd2
  - constant CMP_W=4
  - function for next-requester round-robin search
- One sub-module: the existing `comparator`, instantiated once on op_a/op_b.
- Arbitration and the FSM stay in cmp_arbiter.

Test Plan:
1. Single request: after reset, req_valid=0001, A0=10, B0=12.
   - req_ready=0001 in cycle 0.
   - Cycle 2: rsp_valid=1, rsp_id=0, less=1, equal=0, greater=0.
2. All requesters valid continuously with rsp_ready=1. Operands: r0 15/11, r1 10/10, r2 3/9, r3 0/0.
   - Grants in order 0,1,2,3,0.
   - Responses greater, equal, less, equal.
   - Grants spaced exactly 3 cycles apart.
3. Backpressure: rsp_ready=0 for 5 cycles after rsp_valid rises.
   - rsp_* stays stable.
   - req_ready stays 0 for all requesters throughout.
   - Releasing rsp_ready returns the block to IDLE on the next edge.
4. Wrap-around: rr_ptr=3 (just served r2), req_valid=1001.
   - Grant goes to r3, then r0.
   - Next response rsp_id=0.
5. Reset mid-operation: assert rst in CMP with A=7, B=2.
   - Next cycle: rsp_valid=0, busy=0, rr_ptr=0.
   - No response for that request; a fresh req_valid=0010 is granted normally.
6. Boundaries: A=15, B=0 -> greater. A=0, B=15 -> less. A=15, B=15 -> equal.
   - Requester drops req_valid before its grant -> never granted, no response.
